// File: rtl/counter_down_timer.sv
// Programmable down-counting timer with clamp-on-load, one-shot and auto-reload
// modes, and a registered terminal-count pulse.
package util_pkg;
  typedef struct packed {
    logic clk;
    logic rst;
  } Util_Control_T;
endpackage

module counter_down_timer
  import util_pkg::*;
#(
  parameter int MAX   = 12,
  parameter int WIDTH = $clog2(MAX+1)
) (
  input  util_pkg::Util_Control_T i_ctrl,
  input  logic [WIDTH-1:0]        i_d,
  input  logic                    i_load,
  input  logic                    i_enable,
  input  logic                    i_auto,
  output logic [WIDTH-1:0]        o_q,
  output logic                    o_zero,
  output logic                    o_tick,
  output logic                    o_busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

  logic             w_clk;
  logic             w_rst;
  logic [WIDTH-1:0] w_clamp;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] r_rl;
  logic [WIDTH-1:0] w_rl_nxt;
  logic             r_tick;
  logic             w_tick_nxt;

  assign w_clk   = i_ctrl.clk;
  assign w_rst   = i_ctrl.rst;
  assign w_clamp = (i_d > LP_MAX) ? LP_MAX : i_d;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_rl    <= LP_MAX;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_rl    <= w_rl_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Load beats counting; q==0 while running is the auto-reload pause cycle,
  // so the reload period is rl+1 enabled cycles and q never underflows.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_rl_nxt    = r_rl;
    w_tick_nxt  = 1'b0;
    if (i_load) begin
      w_q_nxt     = w_clamp;
      w_rl_nxt    = w_clamp;
      w_state_nxt = (w_clamp != '0) ? RUN : IDLE;
    end else if (i_enable && (r_state == RUN)) begin
      if (r_q > LP_ONE) begin
        w_q_nxt = r_q - LP_ONE;
      end else if (r_q == LP_ONE) begin
        w_q_nxt     = '0;
        w_tick_nxt  = 1'b1;
        w_state_nxt = i_auto ? RUN : IDLE;
      end else if (i_auto) begin
        w_q_nxt = r_rl;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    o_q    = r_q;
    o_zero = (r_q == '0);
    o_tick = r_tick;
    o_busy = (r_state == RUN);
  end

endmodule

// File: tb/tb_counter_down_timer.sv
// Directed bench for counter_down_timer: reset, one-shot, auto-reload, clamp,
// enable gaps with auto drop, and asynchronous reset mid-count.
module tb_counter_down_timer;
  import util_pkg::*;

  localparam int MAX = 12;
  localparam int W   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  Util_Control_T ctrl;
  logic [W-1:0]  d = '0;
  logic          load = 1'b0;
  logic          enable = 1'b0;
  logic          auto_m = 1'b0;
  logic [W-1:0]  q;
  logic          zero, tick, busy;

  int checks = 0;
  int errors = 0;

  assign ctrl.clk = clk;
  assign ctrl.rst = rst;

  always #5 clk = ~clk;

  counter_down_timer #(.MAX(MAX)) dut (
    .i_ctrl(ctrl), .i_d(d), .i_load(load), .i_enable(enable), .i_auto(auto_m),
    .o_q(q), .o_zero(zero), .o_tick(tick), .o_busy(busy)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; load = 1'b0; auto_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (q !== 4'd0 || zero !== 1'b1 || busy !== 1'b0 || tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: q=%0d zero=%b busy=%b tick=%b, want q=0 zero=1 busy=0 tick=0", i, q, zero, busy, tick);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (q !== 4'd0 || zero !== 1'b1 || busy !== 1'b0 || tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_noload cyc%0d: q=%0d zero=%b busy=%b tick=%b, want q=0 zero=1 busy=0 tick=0", i, q, zero, busy, tick);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_q [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    auto_m = 1'b0; enable = 1'b0; load = 1'b1; d = 4'd5;
    step();
    checks++;
    if (q !== 4'd5 || busy !== 1'b1 || tick !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_load: q=%0d busy=%b tick=%b, want q=5 busy=1 tick=0", q, busy, tick);
    end
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (q !== exp_q[i] || tick !== (i == 4)) begin
        errors++;
        $display("FAIL oneshot_count step%0d: q=%0d tick=%b, want q=%0d tick=%b", i, q, tick, exp_q[i], (i == 4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (q !== 4'd0 || busy !== 1'b0 || tick !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_idle cyc%0d: q=%0d busy=%b tick=%b, want q=0 busy=0 tick=0", i, q, busy, tick);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [W-1:0] exp_q [11] = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
    int ticks = 0;
    int last_tick = -1;
    auto_m = 1'b1; enable = 1'b1; load = 1'b1; d = 4'd3;
    step();
    checks++;
    if (q !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL auto_load: q=%0d busy=%b, want q=3 busy=1", q, busy);
    end
    load = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      checks++;
      if (q !== exp_q[i] || busy !== 1'b1 || tick !== (exp_q[i] == 4'd0)) begin
        errors++;
        $display("FAIL auto_count step%0d: q=%0d busy=%b tick=%b, want q=%0d busy=1 tick=%b", i, q, busy, tick, exp_q[i], (exp_q[i] == 4'd0));
      end
      if (tick === 1'b1) begin
        if (last_tick >= 0) begin
          checks++;
          if (i - last_tick != 4) begin
            errors++;
            $display("FAIL auto_spacing: got %0d cycles, want 4", i - last_tick);
          end
        end
        last_tick = i;
        ticks++;
      end
    end
    checks++;
    if (ticks != 3) begin
      errors++;
      $display("FAIL auto_tick_count: got %0d, want 3", ticks);
    end
  endtask

  task automatic test_clamp_priority();
    auto_m = 1'b0; enable = 1'b1; load = 1'b1; d = 4'd15;
    step();
    checks++;
    if (q !== 4'd12 || busy !== 1'b1 || tick !== 1'b0) begin
      errors++;
      $display("FAIL clamp_load: q=%0d busy=%b tick=%b, want q=12 busy=1 tick=0", q, busy, tick);
    end
    load = 1'b0;
    step();
    checks++;
    if (q !== 4'd11) begin
      errors++;
      $display("FAIL clamp_next: q=%0d, want 11", q);
    end
    load = 1'b1; d = 4'd0;
    step();
    checks++;
    if (q !== 4'd0 || busy !== 1'b0 || tick !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL load_zero: q=%0d busy=%b tick=%b zero=%b, want q=0 busy=0 tick=0 zero=1", q, busy, tick, zero);
    end
    load = 1'b0;
    step();
    checks++;
    if (q !== 4'd0 || busy !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL load_zero_after: q=%0d busy=%b tick=%b, want q=0 busy=0 tick=0", q, busy, tick);
    end
  endtask

  task automatic test_enable_gaps();
    logic [W-1:0] exp_q [10] = '{4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
    logic         exp_t [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    auto_m = 1'b1; enable = 1'b0; load = 1'b1; d = 4'd2;
    step();
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      enable = i[0];
      step();
      checks++;
      if (q !== exp_q[i] || tick !== exp_t[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL gaps step%0d: q=%0d tick=%b busy=%b, want q=%0d tick=%b busy=1", i, q, tick, busy, exp_q[i], exp_t[i]);
      end
    end
    auto_m = 1'b0; enable = 1'b0;
    step();
    checks++;
    if (q !== 4'd0 || busy !== 1'b1 || tick !== 1'b0) begin
      errors++;
      $display("FAIL auto_drop_disabled: q=%0d busy=%b tick=%b, want q=0 busy=1 tick=0", q, busy, tick);
    end
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (q !== 4'd0 || busy !== 1'b0 || tick !== 1'b0) begin
        errors++;
        $display("FAIL auto_drop cyc%0d: q=%0d busy=%b tick=%b, want q=0 busy=0 tick=0", i, q, busy, tick);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    auto_m = 1'b0; enable = 1'b0; load = 1'b1; d = 4'd9;
    step();
    load = 1'b0; enable = 1'b1;
    repeat (4) step();
    checks++;
    if (q !== 4'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: q=%0d busy=%b, want q=5 busy=1", q, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 4'd0 || busy !== 1'b0 || zero !== 1'b1 || tick !== 1'b0 || dut.r_rl !== 4'd12) begin
      errors++;
      $display("FAIL mid_async: q=%0d busy=%b zero=%b tick=%b rl=%0d, want q=0 busy=0 zero=1 tick=0 rl=12", q, busy, zero, tick, dut.r_rl);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q !== 4'd0 || busy !== 1'b0 || tick !== 1'b0) begin
        errors++;
        $display("FAIL mid_release cyc%0d: q=%0d busy=%b tick=%b, want q=0 busy=0 tick=0", i, q, busy, tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_clamp_priority();
    test_enable_gaps();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_down_timer.md
Name: counter_down_timer

Overview:
- Programmable down-counting timer; the count-down counterpart of the up-counter in the Counter library.
- Loaded with a start value, it decrements on enabled cycles and emits a registered terminal-count pulse on reaching zero.
- Supports one-shot and auto-reload operation.
- Sits beside the up-counter, used for pipeline stall/delay timing and periodic event generation.

Parameters:
MAX, 12, largest count value; loads above MAX are clamped to MAX
WIDTH, $clog2(MAX+1), width of d and q

Ports:
- ctrl  input  Util_Control_T  control bundle carrying the clock and reset fields. One clock; reset is asynchronous and active-high. Posedge of the clock field; reset field high clears the block asynchronously.
- d  input  WIDTH  start/reload value, sampled when load=1
- load  input  1  load d (clamped) into q and the reload register
- enable  input  1  count-enable; block holds when low
- auto  input  1  1 = auto-reload mode, 0 = one-shot mode; sampled every cycle
- q  output  WIDTH  current count
- zero  output  1  combinational, q==0
- tick  output  1  registered one-cycle pulse, high in the cycle q first equals 0 after a decrement
- busy  output  1  state==RUN

Behaviour:
- Internal registers:
  - q
  - rl, the reload register, WIDTH bits
  - state, either IDLE or RUN
  - tick
- Reset (asynchronous, any time, including mid-count) sets q=0, rl=MAX, state=IDLE, tick=0, busy=0, zero=1. Release is synchronous to the next posedge.
- Clamp: c = (d>MAX) ? MAX : d.
- Priority per posedge: reset > load > enable > hold.
- Load, in any state, regardless of enable or auto:
  - q<=c, rl<=c, tick<=0.
  - state<=RUN if c!=0, else IDLE.
  - No decrement occurs in a load cycle.
- enable=0 and load=0: q, rl and state hold; tick<=0.
- IDLE with enable=1: q holds; tick<=0. There is no wrap; a load is required to restart.
- RUN with enable=1:
  - q>1: q<=q-1, tick<=0.
  - q==1: q<=0, tick<=1. Then state<=RUN if auto=1, else state<=IDLE.
  - q==0 (auto-reload pause cycle) with auto=1: q<=rl, tick<=0, stay RUN.
  - q==0 with auto=0 (auto dropped): state<=IDLE, q stays 0, tick<=0.
- Auto-reload period: rl+1 enabled cycles per tick. Disabled cycles stretch the period without losing phase.
- tick is never high for two consecutive cycles. It is not asserted on a load to 0, or on reset.
- Arithmetic: decrement is unsigned WIDTH-bit. q never underflows, because 0 is handled by the reload/idle rules.

Test Plan:
- Reset behaviour:
  - Stimulus: assert reset with enable=1 for 2 cycles, then release.
  - Required response: q=0, zero=1, busy=0, tick=0 throughout. With no load, q stays 0 for 4 enabled cycles.
- One-shot count:
  - Stimulus: auto=0; load d=5 for 1 cycle; then enable=1.
  - Required response: q = 5,4,3,2,1,0. tick=1 only in the cycle q becomes 0. Then busy=0 and q holds 0 for 4 more cycles.
- Auto-reload count:
  - Stimulus: auto=1; load d=3; enable=1 for 12 cycles.
  - Required response: q = 3,2,1,0,3,2,1,0,3,2,1,0. tick pulses exactly 3 times, spaced 4 cycles apart. busy stays 1.
- Clamp and priority:
  - Stimulus: load d=15 with MAX=12 while enable=1.
  - Required response: q=12 with no decrement in the load cycle; next enabled cycle q=11.
  - Stimulus: load d=0.
  - Required response: q=0, busy=0, tick=0.
- Enable gaps and auto drop:
  - Stimulus: auto=1, load 2; toggle enable every other cycle.
  - Required response: q decrements only on enabled cycles, and tick is aligned to the enabled step into 0.
  - Stimulus: drop auto while q==0, then apply the next enabled cycle.
  - Required response: busy=0 and q stays 0.
- Reset mid-count:
  - Stimulus: load 9, run 4 enabled cycles (q=5), assert reset asynchronously between clock edges.
  - Required response: q=0 immediately, busy=0, rl=MAX. After release, enable alone keeps q=0.
